// File: rtl/spi_egress_pkg.sv
// Shared types and constants for the SPI egress arbiter.
// Holds the FSM state enum, default marks and header helper.
package spi_egress_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  localparam logic [3:0] DEF_HDR_MARK  = 4'hA;
  localparam logic [7:0] DEF_IDLE_BYTE = 8'hBC;
  localparam int         CNT_W         = 16;

  // Header byte: mark nibble, two zero bits, source index.
  function automatic logic [7:0] hdr_byte(
    input logic [3:0] mark,
    input logic [1:0] src
  );
    return {mark, 2'b00, src};
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: first requester after the last grant.
// Purely combinational, wraps N_SRC-1 back to 0.
module rr_select #(
  parameter int N_SRC = 2
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [1:0]       i_last,
  output logic [1:0]       o_next,
  output logic             o_any
);

  logic [3:0] w_req4;
  logic [1:0] w_idx;

  // Pad the request vector so a 2-bit index is always in range
  always_comb begin
    w_req4 = '0;
    w_req4[N_SRC-1:0] = i_req;
  end

  // Scan from the farthest candidate down so the nearest one wins
  always_comb begin
    o_next = i_last;
    o_any  = |i_req;
    w_idx  = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      w_idx = 2'((int'(i_last) + k) % N_SRC);
      if (w_req4[w_idx]) begin
        o_next = w_idx;
      end
    end
  end

endmodule

// File: rtl/spi_egress_arbiter.sv
// Merges N_SRC AXIS byte sources into one headered byte stream.
// Whole packets per grant, round-robin, single output register.
module spi_egress_arbiter
  import spi_egress_pkg::*;
#(
  parameter int         N_SRC     = 2,
  parameter logic [3:0] HDR_MARK  = DEF_HDR_MARK,
  parameter logic [7:0] IDLE_BYTE = DEF_IDLE_BYTE,
  parameter int         MAX_LEN   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]   s_axis_tvalid,
  input  logic [N_SRC-1:0]   s_axis_tlast,
  output logic [N_SRC-1:0]   s_axis_tready,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [7:0]         m_axis_tuser,
  output logic [1:0]         grant,
  output logic               busy
);

  localparam logic [1:0]  RST_GRANT = 2'(N_SRC - 1);
  localparam logic [16:0] LEN_LIM   = 17'(MAX_LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_tdata;
  logic [7:0]       w_tdata_nxt;
  logic             r_tvalid;
  logic             w_tvalid_nxt;
  logic             r_hdr_ld;
  logic             w_hdr_ld_nxt;

  logic [1:0]  w_rr_next;
  logic        w_rr_any;
  logic [3:0]  w_valid4;
  logic [3:0]  w_last4;
  logic [31:0] w_data4;
  logic [3:0]  w_rdy4;
  logic        w_out_free;
  logic        w_src_valid;
  logic        w_src_last;
  logic [7:0]  w_src_data;
  logic        w_src_fire;
  logic        w_cnt_done;

  rr_select #(
    .N_SRC (N_SRC)
  ) u_rr (
    .i_req  (s_axis_tvalid),
    .i_last (r_grant),
    .o_next (w_rr_next),
    .o_any  (w_rr_any)
  );

  // Widen source buses to four lanes and pick the granted lane
  always_comb begin
    w_valid4 = 4'(s_axis_tvalid);
    w_last4  = 4'(s_axis_tlast);
    w_data4  = 32'(s_axis_tdata);
    w_src_valid = w_valid4[r_grant];
    w_src_last  = w_last4[r_grant];
    w_src_data  = w_data4[{r_grant, 3'b000} +: 8];
  end

  // Only the granted source sees ready, and only while in DATA
  always_comb begin
    w_out_free = !r_tvalid || m_axis_tready;
    w_rdy4 = '0;
    if (r_state == ST_DATA) begin
      w_rdy4[r_grant] = w_out_free;
    end
    s_axis_tready = w_rdy4[N_SRC-1:0];
    w_src_fire = (r_state == ST_DATA)
               && w_src_valid && w_out_free;
    w_cnt_done = ({1'b0, r_cnt} + 17'd1) == LEN_LIM;
  end

  // Next-state, grant, counter and output-register logic
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_cnt_nxt    = r_cnt;
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    w_hdr_ld_nxt = r_hdr_ld;
    if (r_tvalid && m_axis_tready) begin
      w_tvalid_nxt = 1'b0;
    end
    unique case (r_state)
      ST_IDLE: begin
        if (w_rr_any) begin
          w_grant_nxt  = w_rr_next;
          w_hdr_ld_nxt = 1'b0;
          w_state_nxt  = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!r_hdr_ld) begin
          if (w_out_free) begin
            w_tdata_nxt  = hdr_byte(HDR_MARK, r_grant);
            w_tvalid_nxt = 1'b1;
            w_hdr_ld_nxt = 1'b1;
          end
        end else if (r_tvalid && m_axis_tready) begin
          w_hdr_ld_nxt = 1'b0;
          w_state_nxt  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_src_fire) begin
          w_tdata_nxt  = w_src_data;
          w_tvalid_nxt = 1'b1;
          if (w_src_last || w_cnt_done) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output register; reset drops any pending byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= RST_GRANT;
      r_cnt    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_hdr_ld <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_hdr_ld <= w_hdr_ld_nxt;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = IDLE_BYTE;
  assign grant         = r_grant;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_egress_arbiter.sv
// Bench for spi_egress_arbiter: directed steps plus random traffic.
// Expected stream comes from a packet-level round-robin model.
module tb_spi_egress_arbiter;

  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tlast;
  logic [1:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tuser;
  logic [1:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  spi_egress_arbiter #(
    .N_SRC   (2),
    .MAX_LEN (ML)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .grant         (grant),
    .busy          (busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [8:0] srcq [2][$];
  logic [8:0] mq [2][$];
  logic [7:0] obs [$];
  logic [7:0] exp_q [$];
  bit         en [2];
  bit         rnd_rdy;
  int         stab_err;
  bit         stalled_prev;
  logic [7:0] prev_d;
  bit         rdy1_seen;
  int         model_last;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock: drive, observe handshakes, then advance past the edge
  task automatic cyc();
    for (int s = 0; s < 2; s++) begin
      if (en[s] && srcq[s].size() > 0) begin
        s_tvalid[s] = 1'b1;
        s_tdata[8*s +: 8] = srcq[s][0][7:0];
        s_tlast[s] = srcq[s][0][8];
      end else begin
        s_tvalid[s] = 1'b0;
        s_tdata[8*s +: 8] = 8'h00;
        s_tlast[s] = 1'b0;
      end
    end
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (stalled_prev && !(m_tvalid && m_tdata === prev_d))
      stab_err++;
    stalled_prev = m_tvalid && !m_tready && !rst;
    prev_d = m_tdata;
    if (m_tvalid && m_tready && !rst) obs.push_back(m_tdata);
    for (int s = 0; s < 2; s++) begin
      if (s_tvalid[s] && s_tready[s]) void'(srcq[s].pop_front());
    end
    if (s_tready[1]) rdy1_seen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int n, input int budget,
                           input string tag);
    int c;
    c = 0;
    while (obs.size() < n && c < budget) begin
      cyc();
      c++;
    end
    chk({tag, "_done"}, 16'(obs.size() >= n), 16'd1);
  endtask

  task automatic push_src(input int s, input logic [8:0] v);
    srcq[s].push_back(v);
  endtask

  task automatic push_both(input int s, input logic [8:0] v);
    srcq[s].push_back(v);
    mq[s].push_back(v);
  endtask

  // Packet-level model: alternate to the other source if it has
  // data, emit header then bytes up to tlast or ML bytes.
  task automatic model_build();
    int c;
    int n;
    bit done;
    logic [8:0] b;
    while (mq[0].size() + mq[1].size() > 0) begin
      c = (model_last + 1) % 2;
      if (mq[c].size() == 0) c = model_last;
      model_last = c;
      exp_q.push_back(8'hA0 + 8'(c));
      n = 0;
      done = 1'b0;
      while (!done) begin
        b = mq[c].pop_front();
        exp_q.push_back(b[7:0]);
        n++;
        done = b[8] || n == ML || mq[c].size() == 0;
      end
    end
  endtask

  task automatic chk_stream(input string tag);
    int m;
    chk({tag, "_len"}, 16'(obs.size()), 16'(exp_q.size()));
    m = obs.size() < exp_q.size() ? obs.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s[%0d]", tag, i),
          16'(obs[i]), 16'(exp_q[i]));
    end
  endtask

  task automatic clear_all();
    for (int s = 0; s < 2; s++) begin
      srcq[s].delete();
      mq[s].delete();
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    model_last = 1;
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b1;
    en[0] = 1'b1;
    en[1] = 1'b1;
    rnd_rdy = 1'b0;
    stab_err = 0;
    stalled_prev = 1'b0;
    prev_d = '0;
    rdy1_seen = 1'b0;
    model_last = 1;
    @(posedge clk);
    #1;
    cyc();
    cyc();
    chk("rst_tvalid", 16'(m_tvalid), 16'd0);
    chk("rst_tdata", 16'(m_tdata), 16'h00);
    chk("rst_sready", 16'(s_tready), 16'd0);
    chk("rst_grant", 16'(grant), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("tuser", 16'(m_tuser), 16'hBC);
    rst = 1'b0;

    push_src(0, {1'b0, 8'h11});
    push_src(0, {1'b0, 8'h22});
    push_src(0, {1'b1, 8'h33});
    run_until(4, 40, "t1");
    chk("t1_hdr", 16'(obs[0]), 16'hA0);
    chk("t1_b0", 16'(obs[1]), 16'h11);
    chk("t1_b1", 16'(obs[2]), 16'h22);
    chk("t1_b2", 16'(obs[3]), 16'h33);
    repeat (3) cyc();
    chk("t1_busy", 16'(busy), 16'd0);
    chk("t1_grant", 16'(grant), 16'd0);

    do_reset();
    push_both(0, {1'b0, 8'h01});
    push_both(0, {1'b1, 8'h02});
    push_both(0, {1'b0, 8'h03});
    push_both(0, {1'b1, 8'h04});
    push_both(1, {1'b0, 8'h05});
    push_both(1, {1'b1, 8'h06});
    push_both(1, {1'b0, 8'h07});
    push_both(1, {1'b1, 8'h08});
    model_build();
    run_until(exp_q.size(), 100, "t2");
    chk_stream("t2");

    obs.delete();
    exp_q.delete();
    for (int i = 1; i <= 6; i++)
      push_both(1, {i == 6, 8'(i)});
    model_build();
    run_until(exp_q.size(), 100, "t3");
    chk_stream("t3");
    chk("t3_hdr2", 16'(obs[5]), 16'hA1);

    obs.delete();
    exp_q.delete();
    rnd_rdy = 1'b1;
    stab_err = 0;
    for (int p = 0; p < 12; p++) begin
      int s;
      int len;
      s = $urandom_range(0, 1);
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++)
        push_both(s, {j == len - 1, 8'($urandom)});
    end
    model_build();
    run_until(exp_q.size(), 2000, "t4");
    repeat (4) cyc();
    chk_stream("t4");
    chk("t4_stable", 16'(stab_err), 16'd0);
    chk("t4_drain", 16'(srcq[0].size() + srcq[1].size()), 16'd0);
    rnd_rdy = 1'b0;

    do_reset();
    push_src(0, {1'b0, 8'h10});
    push_src(0, {1'b0, 8'h20});
    push_src(0, {1'b1, 8'h30});
    run_until(3, 40, "t5a");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_tvalid", 16'(m_tvalid), 16'd0);
    chk("t5_busy", 16'(busy), 16'd0);
    clear_all();
    model_last = 1;
    push_both(0, {1'b0, 8'h40});
    push_both(0, {1'b1, 8'h50});
    model_build();
    run_until(exp_q.size(), 40, "t5b");
    chk_stream("t5");

    do_reset();
    push_both(0, {1'b0, 8'h71});
    push_both(0, {1'b0, 8'h72});
    push_both(0, {1'b1, 8'h73});
    push_both(1, {1'b0, 8'h81});
    push_both(1, {1'b1, 8'h82});
    model_build();
    run_until(2, 40, "t6a");
    en[0] = 1'b0;
    rdy1_seen = 1'b0;
    repeat (5) cyc();
    chk("t6_rdy1", 16'(rdy1_seen), 16'd0);
    chk("t6_grant", 16'(grant), 16'd0);
    chk("t6_busy", 16'(busy), 16'd1);
    en[0] = 1'b1;
    run_until(exp_q.size(), 60, "t6b");
    chk_stream("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_egress_arbiter.md
SPI_EGRESS_ARBITER -- requirements
Module: spi_egress_arbiter

Interface
REQ-001 SHALL take parameter N_SRC, default 2, number of AXIS byte sources (range 1..4).
REQ-002 SHALL take parameter HDR_MARK, default 4'hA, upper nibble of the per-packet header byte.
REQ-003 SHALL take parameter IDLE_BYTE, default 8'hBC, filler byte driven on m_axis_tuser.
REQ-004 SHALL take parameter MAX_LEN, default 256, maximum payload bytes per grant (range 1..65535).
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port s_axis_tdata, input, 8*N_SRC, per-source data; source i occupies bits [8i+7:8i].
REQ-008 SHALL have port s_axis_tvalid, input, N_SRC, per-source valid.
REQ-009 SHALL have port s_axis_tlast, input, N_SRC, per-source end of packet.
REQ-010 SHALL have port s_axis_tready, output, N_SRC, per-source ready.
REQ-011 SHALL have port m_axis_tdata, output, 8, merged byte stream towards the SPI egress.
REQ-012 SHALL have port m_axis_tvalid, output, 1, merged valid.
REQ-013 SHALL have port m_axis_tready, input, 1, egress ready.
REQ-014 SHALL have port m_axis_tuser, output, 8, constant IDLE_BYTE.
REQ-015 SHALL have port grant, output, 2, index of the source currently or last granted.
REQ-016 SHALL have port busy, output, 1, high in HEADER or DATA.

Function
REQ-017 SHALL have three states: IDLE, HEADER, DATA.
REQ-018 IDLE: a source is pending when its tvalid is high. If any source is pending, the FSM SHALL pick the first pending index after the last grant (round-robin, wrapping N_SRC-1 -> 0), update grant and go to HEADER on the next clk.
REQ-019 HEADER: the output register SHALL load {HDR_MARK, 2'b00, grant} with tvalid high; once that byte is accepted (tvalid and tready high), the FSM SHALL go to DATA.
REQ-020 DATA: s_axis_tready[grant] SHALL equal (!m_axis_tvalid || m_axis_tready); every other s_axis_tready bit SHALL be 0.
REQ-021 DATA: each accepted source byte SHALL load the output register and increment a 16-bit payload counter.
REQ-022 DATA: the FSM SHALL return to IDLE after accepting a byte with tlast high, or after the byte that brings the counter to MAX_LEN; a truncated packet resumes with a fresh header at its next grant.
REQ-023 The output stage SHALL be a single register: latency from source acceptance to m_axis_tvalid is 1 clk; throughput is 1 byte/clk while m_axis_tready stays high.
REQ-024 m_axis_tvalid SHALL NOT deassert and m_axis_tdata SHALL NOT change while m_axis_tvalid is high and m_axis_tready is low.
REQ-025 The arbiter SHALL never switch source mid-packet, and SHALL never take bytes from a source in IDLE or HEADER.
REQ-026 A source dropping tvalid mid-packet SHALL stall DATA and keep the grant; the SPI side then transmits m_axis_tuser filler.
REQ-027 The 1 clk IDLE turnaround between packets SHALL be allowed, and the output register SHALL drain normally during it.
REQ-028 With N_SRC=1, grant SHALL stay 0 and headers SHALL still be emitted.

Reset
REQ-029 On rst high at a clk edge, the block SHALL go to IDLE with: m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, grant=N_SRC-1 (so source 0 wins first), counter=0, busy=0.
REQ-030 rst mid-packet SHALL abort immediately and discard any pending output byte; the next packet SHALL start with a header.

Structure
REQ-031 A shared package spi_egress_pkg SHALL hold the state enum, the default HDR_MARK and IDLE_BYTE constants, and the header-byte construction function.
REQ-032 The round-robin selector SHALL be a sub-module rr_select (inputs: request vector, last grant; outputs: next grant, any-request), purely combinational.

Verification
REQ-033 Source 0 sends 3-byte packet 11,22,33 (tlast on 33) with m_axis_tready held high -> output A0,11,22,33, busy falls, grant=0.
REQ-034 Sources 0 and 1 both continuously valid with 2-byte packets -> packet order: src0, src1, src0, src1; headers alternate A0/A1.
REQ-035 With MAX_LEN=4, source 1 streams 6 bytes 01..06 with tlast only on 06 -> output A1,01..04, then later A1,05,06.
REQ-036 m_axis_tready toggles randomly, with 50% duty -> no byte lost or duplicated, and m_axis_tdata stays stable while stalled.
REQ-037 rst asserted after the second payload byte -> m_axis_tvalid=0 on the next clk, and the following packet starts with a header byte.
REQ-038 Source 0 drops tvalid for 5 clk mid-packet while source 1 is valid -> s_axis_tready[1] stays 0 and source 0 completes first.
